// File: rtl/div_16b_seq.sv
// Unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results are registered and held until the next accepted start or reset.
module div_16b_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    count;

  logic [WIDTH+1:0] sh_prem;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH:0]   prem_nx;
  logic [WIDTH-1:0] qreg_nx;

  // Trial subtraction carries a spare sign bit so divisors >= 2^(WIDTH-1) cannot overflow.
  always_comb begin
    sh_prem = {prem, qreg[WIDTH-1]};
    trial   = sh_prem - {2'b00, dvsr};
    fits    = ~trial[WIDTH+1];
    prem_nx = fits ? trial[WIDTH:0] : sh_prem[WIDTH:0];
    qreg_nx = {qreg[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      prem        <= '0;
      qreg        <= '0;
      dvsr        <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              prem  <= '0;
              qreg  <= dividend;
              dvsr  <= divisor;
              count <= '0;
            end
          end
        end
        RUN: begin
          prem  <= prem_nx;
          qreg  <= qreg_nx;
          count <= count + 1'b1;
          if (count == LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= qreg_nx;
            remainder   <= prem_nx[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16b_seq.sv
// Directed and random bench for div_16b_seq with a queue of expected results.
module tb_div_16b_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  div_16b_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one divide in the current cycle; leaves the bench in the done cycle when b2b=1.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input bit b2b, input int inj, input string tag);
    exp_t        e;
    int          cyc;
    int          busy_cnt;
    bit          held;
    logic [15:0] pq;
    logic [15:0] pr;
    e.a  = a;
    e.b  = b;
    e.q  = (b == 16'd0) ? 16'hFFFF : a / b;
    e.r  = (b == 16'd0) ? a : a % b;
    e.dz = (b == 16'd0);
    sb.push_back(e);
    pq = quotient;
    pr = remainder;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    held     = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (quotient !== pq || remainder !== pr) held = 1'b0;
      if (cyc == inj) begin
        start    = 1'b1;
        dividend = 16'd200;
        divisor  = 16'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), (b == 16'd0) ? 32'd1 : 32'd17);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), (b == 16'd0) ? 32'd0 : 32'd16);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_held_during_run"}, 32'(held), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
      if (e.b != 16'd0) begin
        check({tag, "_invariant"}, 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
        check({tag, "_rem_lt_div"}, 32'(remainder < e.b), 32'd1);
      end
      if (!b2b) begin
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold_q"}, 32'(quotient), 32'(e.q));
        check({tag, "_hold_r"}, 32'(remainder), 32'(e.r));
      end
    end
  endtask

  initial begin
    int seen;
    logic [15:0] ra;
    logic [15:0] rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    run_div(16'd100, 16'd7, 1'b0, 0, "d100_7");
    check("d100_7_const_q", 32'(quotient), 32'd14);
    check("d100_7_const_r", 32'(remainder), 32'd2);
    run_div(16'hFFFF, 16'd1, 1'b0, 0, "dffff_1");
    run_div(16'hFFFF, 16'h8001, 1'b0, 0, "dffff_8001");
    check("dffff_8001_const_r", 32'(remainder), 32'h7FFE);
    run_div(16'd5, 16'd0, 1'b0, 0, "d5_0");
    run_div(16'd3, 16'd10, 1'b0, 5, "d3_10_ignore");
    check("d3_10_const_q", 32'(quotient), 32'd0);
    check("d3_10_const_r", 32'(remainder), 32'd3);

    // Abort a divide with reset in the eighth RUN cycle.
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    seen = 0;
    repeat (30) begin
      if (done) seen++;
      tick();
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run_div(16'd1000, 16'd3, 1'b1, 0, "d1000_3");
    check("d1000_3_const_q", 32'(quotient), 32'd333);
    run_div(16'd81, 16'd9, 1'b0, 0, "b2b_81_9");
    check("b2b_81_9_const_q", 32'(quotient), 32'd9);
    run_div(16'hFFFF, 16'hFFFF, 1'b0, 0, "dffff_ffff");
    check("dffff_ffff_const_q", 32'(quotient), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      run_div(ra, rb, (i % 8 == 0), 0, "rand");
    end

    check("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
